// File: rtl/udp_checksum_calc.sv
// UDP checksum generator: accumulates pseudo-header, UDP header and payload
// beats into a one's-complement sum and pushes {udp_len, checksum} to a FIFO.
module udp_checksum_calc #(
    parameter logic [7:0] PROTO     = 8'h11,
    parameter int         ACC_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_start,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [15:0] udp_len,
    input  logic        s_data_vld,
    input  logic [31:0] s_data,
    input  logic [3:0]  s_data_keep,
    input  logic        s_data_last,
    output logic        s_data_rdy,
    input  logic        fifo_wr_vld,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    output logic        busy,
    output logic        err_len
);

    typedef enum logic [2:0] {IDLE, DATA, FOLD1, FOLD2, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [ACC_WIDTH-1:0]   byte_cnt_q, byte_cnt_d;
    logic [15:0]            udp_len_q, udp_len_d;
    logic [31:0]            wr_data_q, wr_data_d;
    logic                   err_q, err_d;

    logic [3:0]             keep_s;
    logic [31:0]            masked_s;
    logic [15:0]            csum_s;

    // Only the four MSB-first contiguous patterns are legal on the last beat.
    function automatic logic [3:0] keep_eff(input logic [3:0] keep, input logic last);
        logic [3:0] res;
        if (!last) begin
            res = 4'b1111;
        end else begin
            case (keep)
                4'b1000, 4'b1100, 4'b1110, 4'b1111: res = keep;
                default:                            res = 4'b1111;
            endcase
        end
        return res;
    endfunction

    function automatic logic [2:0] popcnt4(input logic [3:0] k);
        logic [2:0] res;
        res = 3'd0;
        for (int i = 0; i < 4; i++) begin
            res = res + {2'b00, k[i]};
        end
        return res;
    endfunction

    function automatic logic [ACC_WIDTH-1:0] fold16(input logic [ACC_WIDTH-1:0] a);
        return ACC_WIDTH'(a[15:0]) + ACC_WIDTH'(a[31:16]);
    endfunction

    // Next-state, datapath and output decode.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        byte_cnt_d   = byte_cnt_q;
        udp_len_d    = udp_len_q;
        wr_data_d    = wr_data_q;
        err_d        = err_q;
        keep_s       = 4'b0000;
        masked_s     = 32'h0000_0000;
        csum_s       = 16'h0000;
        s_data_rdy   = 1'b0;
        fifo_wr_en   = 1'b0;
        err_len      = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_start) begin
                    udp_len_d  = udp_len;
                    // udp_len appears twice: once in the pseudo-header, once in the UDP header.
                    acc_d      = ACC_WIDTH'(src_ip[31:16]) + ACC_WIDTH'(src_ip[15:0])
                               + ACC_WIDTH'(dst_ip[31:16]) + ACC_WIDTH'(dst_ip[15:0])
                               + ACC_WIDTH'(PROTO) + ACC_WIDTH'(udp_len)
                               + ACC_WIDTH'(src_port) + ACC_WIDTH'(dst_port)
                               + ACC_WIDTH'(udp_len);
                    byte_cnt_d = '0;
                    state_d    = (udp_len <= 16'd8) ? FOLD1 : DATA;
                end else begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                s_data_rdy = 1'b1;
                if (s_data_vld) begin
                    keep_s     = keep_eff(s_data_keep, s_data_last);
                    masked_s   = s_data & {{8{keep_s[3]}}, {8{keep_s[2]}}, {8{keep_s[1]}}, {8{keep_s[0]}}};
                    acc_d      = acc_q + ACC_WIDTH'(masked_s[31:16]) + ACC_WIDTH'(masked_s[15:0]);
                    byte_cnt_d = byte_cnt_q + ACC_WIDTH'(popcnt4(keep_s));
                    state_d    = s_data_last ? FOLD1 : DATA;
                end else begin
                    state_d = DATA;
                end
            end
            FOLD1: begin
                acc_d   = fold16(acc_q);
                state_d = FOLD2;
            end
            FOLD2: begin
                acc_d  = fold16(acc_q);
                csum_s = ~acc_d[15:0];
                if (byte_cnt_q != (ACC_WIDTH'(udp_len_q) - ACC_WIDTH'(32'd8))) begin
                    csum_s = 16'h0000;
                    err_d  = 1'b1;
                end else begin
                    // Zero on the wire means "no checksum", so a true zero goes out as all-ones.
                    csum_s = (csum_s == 16'h0000) ? 16'hFFFF : csum_s;
                    err_d  = 1'b0;
                end
                wr_data_d = {udp_len_q, csum_s};
                state_d   = WRITE;
            end
            WRITE: begin
                if (fifo_wr_vld) begin
                    fifo_wr_en = 1'b1;
                    err_len    = err_q;
                    state_d    = IDLE;
                end else begin
                    state_d = WRITE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            byte_cnt_q <= '0;
            udp_len_q  <= 16'h0000;
            wr_data_q  <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            byte_cnt_q <= byte_cnt_d;
            udp_len_q  <= udp_len_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
        end
    end

    assign fifo_wr_data = wr_data_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_udp_checksum_calc.sv
// Directed testbench for udp_checksum_calc with hand-computed checksums.
module tb_udp_checksum_calc;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_start;
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] udp_len;
    logic        s_data_vld;
    logic [31:0] s_data;
    logic [3:0]  s_data_keep;
    logic        s_data_last;
    logic        s_data_rdy;
    logic        fifo_wr_vld;
    logic        fifo_wr_en;
    logic [31:0] fifo_wr_data;
    logic        busy;
    logic        err_len;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_cnt  = 0;

    always #5 clk = ~clk;

    udp_checksum_calc dut (
        .clk          (clk),
        .rst          (rst),
        .s_start      (s_start),
        .src_ip       (src_ip),
        .dst_ip       (dst_ip),
        .src_port     (src_port),
        .dst_port     (dst_port),
        .udp_len      (udp_len),
        .s_data_vld   (s_data_vld),
        .s_data       (s_data),
        .s_data_keep  (s_data_keep),
        .s_data_last  (s_data_last),
        .s_data_rdy   (s_data_rdy),
        .fifo_wr_vld  (fifo_wr_vld),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .busy         (busy),
        .err_len      (err_len)
    );

    // Count every FIFO write the DUT issues.
    always @(posedge clk) begin
        if (fifo_wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_pkt(input string tag,
                           input logic [31:0] sip, input logic [31:0] dip,
                           input logic [15:0] sp, input logic [15:0] dp, input logic [15:0] len,
                           input int nb, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [3:0] keep_last,
                           input logic [31:0] exp_data, input logic exp_err, input int bp);
        int lat;
        int wr0;
        wr0         = wr_cnt;
        fifo_wr_vld = (bp == 0);
        s_start     = 1'b1;
        src_ip      = sip;
        dst_ip      = dip;
        src_port    = sp;
        dst_port    = dp;
        udp_len     = len;
        @(negedge clk);
        s_start = 1'b0;
        for (int i = 0; i < nb; i++) begin
            s_data_vld  = 1'b1;
            s_data      = (i == 0) ? d0 : d1;
            s_data_keep = (i == nb - 1) ? keep_last : 4'b1111;
            s_data_last = (i == nb - 1);
            check_eq({tag, "_rdy"}, {31'd0, s_data_rdy}, 32'd1);
            @(negedge clk);
        end
        s_data_vld  = 1'b0;
        s_data_last = 1'b0;
        if (bp == 0) begin
            lat = 1;
            while (!fifo_wr_en && lat < 12) begin
                @(negedge clk);
                lat++;
            end
            check_eq({tag, "_latency"}, lat, 32'd3);
        end else begin
            repeat (2) @(negedge clk);
            for (int i = 0; i < bp; i++) begin
                check_eq({tag, "_bp_noen"}, {31'd0, fifo_wr_en}, 32'd0);
                check_eq({tag, "_bp_hold"}, fifo_wr_data, exp_data);
                @(negedge clk);
            end
            fifo_wr_vld = 1'b1;
            #1;
        end
        check_eq({tag, "_wr_en"}, {31'd0, fifo_wr_en}, 32'd1);
        check_eq({tag, "_data"}, fifo_wr_data, exp_data);
        check_eq({tag, "_err"}, {31'd0, err_len}, {31'd0, exp_err});
        check_eq({tag, "_rdy_low"}, {31'd0, s_data_rdy}, 32'd0);
        @(negedge clk);
        check_eq({tag, "_wr_en_off"}, {31'd0, fifo_wr_en}, 32'd0);
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_one_write"}, wr_cnt - wr0, 32'd1);
    endtask

    initial begin
        int wr0;
        rst         = 1'b1;
        s_start     = 1'b0;
        src_ip      = 32'h0;
        dst_ip      = 32'h0;
        src_port    = 16'h0;
        dst_port    = 16'h0;
        udp_len     = 16'h0;
        s_data_vld  = 1'b0;
        s_data      = 32'h0;
        s_data_keep = 4'h0;
        s_data_last = 1'b0;
        fifo_wr_vld = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check_eq("rst_data", fifo_wr_data, 32'd0);
        check_eq("rst_err", {31'd0, err_len}, 32'd0);
        check_eq("rst_rdy", {31'd0, s_data_rdy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 0x11+8+8 = 0x21 -> ~ = 0xFFDE
        run_pkt("hdr_only", 32'h0, 32'h0, 16'h0, 16'h0, 16'd8, 0, 32'h0, 32'h0, 4'hF,
                32'h0008_FFDE, 1'b0, 0);
        // 0x29 + 1 + 2 = 0x2C -> 0xFFD3
        run_pkt("one_beat", 32'h0, 32'h0, 16'h0, 16'h0, 16'd12, 1, 32'h0001_0002, 32'h0, 4'b1111,
                32'h000C_FFD3, 1'b0, 0);
        // 0x23 + 0xAB00 = 0xAB23 -> 0x54DC
        run_pkt("odd_len", 32'h0, 32'h0, 16'h0, 16'h0, 16'd9, 1, 32'hAB00_00FF, 32'h0, 4'b1000,
                32'h0009_54DC, 1'b0, 0);
        // 0x27 + 0x1234 + 0x5600 = 0x685B -> 0x97A4
        run_pkt("three_byte", 32'h0, 32'h0, 16'h0, 16'h0, 16'd11, 1, 32'h1234_5678, 32'h0, 4'b1110,
                32'h000B_97A4, 1'b0, 0);
        // 6*0xFFFF + 0x21 = 0x6001B -> fold 0x21 -> 0xFFDE
        run_pkt("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFF, 16'd8, 0, 32'h0, 32'h0, 4'hF,
                32'h0008_FFDE, 1'b0, 0);
        // 0xFFDE + 0x21 = 0xFFFF -> computed 0 -> sent 0xFFFF
        run_pkt("zero_rule", 32'h0000_FFDE, 32'h0, 16'h0, 16'h0, 16'd8, 0, 32'h0, 32'h0, 4'hF,
                32'h0008_FFFF, 1'b0, 0);
        // 8 bytes counted vs 4 expected
        run_pkt("len_err", 32'h0, 32'h0, 16'h0, 16'h0, 16'd12, 2, 32'h1111_2222, 32'h3333_4444, 4'b1111,
                32'h000C_0000, 1'b1, 0);
        // illegal keep 0100 counts as 4 bytes vs 3 expected
        run_pkt("bad_keep", 32'h0, 32'h0, 16'h0, 16'h0, 16'd11, 1, 32'h1234_5678, 32'h0, 4'b0100,
                32'h000B_0000, 1'b1, 0);
        run_pkt("backpress", 32'h0, 32'h0, 16'h0, 16'h0, 16'd12, 1, 32'h0001_0002, 32'h0, 4'b1111,
                32'h000C_FFD3, 1'b0, 5);

        // Abort mid-packet with reset.
        wr0      = wr_cnt;
        s_start  = 1'b1;
        udp_len  = 16'd16;
        @(negedge clk);
        s_start     = 1'b0;
        s_data_vld  = 1'b1;
        s_data      = 32'hDEAD_BEEF;
        s_data_keep = 4'b1111;
        s_data_last = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        s_data_vld = 1'b0;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check_eq("abort_no_write", wr_cnt - wr0, 32'd0);
        run_pkt("after_rst", 32'h0, 32'h0, 16'h0, 16'h0, 16'd12, 1, 32'h0001_0002, 32'h0, 4'b1111,
                32'h000C_FFD3, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
